silent_param_loader: RTL
========================

Name: silent_param_loader

Overview:
- Feeds the silent LPF stage: fetches per-transducer cycle/duty/phase from a synchronous parameter RAM and sanitises each entry.
- Presents the parameter sets as stable arrays and issues a one-cycle START to the LPF.
- Enforces a minimum START spacing so the LPF has always finished its previous pass before it is restarted.

Parameters:
- WIDTH, 13, bit width of cycle/duty/phase.
- DEPTH, 249, number of transducers (RAM entries 0..DEPTH-1).
- RAM_LATENCY, 2, cycles from RAM_ADDR/RAM_EN registered to RAM_DATA valid.
- MIN_INTERVAL, 512, minimum cycles between consecutive START pulses (≥ one full LPF pass).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- UPDATE  in  1  one-cycle request to reload parameters and restart the LPF.
- BUSY  out  1  high from the cycle after UPDATE is accepted until the cycle START is high (inclusive).
- RAM_EN  out  1  RAM read enable.
- RAM_ADDR  out  $clog2(DEPTH)  RAM read address.
- RAM_DATA  in  3*WIDTH  packed entry: [3W-1:2W] cycle, [2W-1:W] duty, [W-1:0] phase.
- CYCLE  out  WIDTH x DEPTH  committed cycle array, to LPF.
- DUTY  out  WIDTH x DEPTH  committed duty array, to LPF.
- PHASE  out  WIDTH x DEPTH  committed phase array, to LPF.
- START  out  1  one-cycle pulse to LPF; arrays are valid and stable in the same cycle.

Behaviour:
- Reset values (async, RST=1):
  - CYCLE/DUTY/PHASE = 0; START = 0; BUSY = 0; RAM_EN = 0; RAM_ADDR = 0.
  - State is IDLE, the pending flag is clear and the interval counter is saturated at MIN_INTERVAL.
- Reset mid-fetch aborts the pass: staged data is discarded and the outputs return to 0.
- All outputs are registered.
- States:
  - IDLE: on UPDATE, go to FETCH, RAM_EN<=1, RAM_ADDR<=0.
  - FETCH: addresses 0..DEPTH-1 are issued on consecutive cycles. Each returned word is captured into staging index i exactly RAM_LATENCY cycles after its address cycle. RAM_EN drops after address DEPTH-1. After the last capture, go to WAIT_GAP.
  - WAIT_GAP: when the interval counter is ≥ MIN_INTERVAL, copy all staged entries to CYCLE/DUTY/PHASE in a single edge, assert START for that one cycle, then go to IDLE.
- Timing: UPDATE high in cycle 0 gives RAM_EN in cycles 1..DEPTH with RAM_ADDR = n-1. Earliest START is cycle DEPTH+RAM_LATENCY+2 (253 at defaults).
- Interval counter: cleared to 0 in the cycle after START, increments each cycle, saturates at MIN_INTERVAL. A subsequent START never occurs before cycle s+MIN_INTERVAL, where s is the previous START cycle.
- Output arrays change only on the START edge (atomic commit). LPF bypass consumers never see a partially updated set.
- Sanitising, per entry, done combinationally at capture. Comparisons are unsigned.
  - cycle==0: store cycle=0, duty=0, phase=0.
  - duty > (cycle>>1): store duty = cycle>>1; otherwise pass duty through.
  - phase ≥ cycle: store phase-cycle (single subtraction, no further folding); otherwise pass phase through.
  - cycle is stored unchanged.
- UPDATE while BUSY sets a one-deep pending flag. Multiple requests merge into one.
  - On return to IDLE with pending set, a new FETCH starts on the next edge and the flag clears.
  - UPDATE coinciding with START also sets pending.
- UPDATE in IDLE with the counter below MIN_INTERVAL: fetch proceeds immediately; only the commit waits.

Test Plan:
- Reset, then UPDATE once with RAM[i]={1000, i, 2i} → START high exactly in cycle 253. Arrays show CYCLE[i]=1000, DUTY[i]=i, PHASE[i]=2i. RAM_ADDR sweeps 0..248 in cycles 1..249.
- Entry {cycle=100, duty=80, phase=130}, plus an entry with cycle=0 → stored {100, 50, 30} and {0, 0, 0}. Entry {100, 50, 99} passes unchanged.
- Two UPDATEs 10 cycles apart → exactly two STARTs. The second fetch begins the cycle after the first START, and the second START falls ≥512 cycles after the first.
- Three UPDATEs during one busy period → only two START pulses in total.
- Monitor the arrays every cycle while RAM content changes during a fetch → arrays change only on START edges, never mid-fetch.
- Assert RST in cycle 100 of a fetch → all outputs 0 immediately. No START follows. The next UPDATE yields START at cycle 253 relative to it, with no interval wait.

Source files
------------

// File: rtl/silent_param_loader.sv
// rtl/silent_param_loader.sv - Fetches, sanitises and atomically commits per-transducer LPF parameters.
module silent_param_loader #(
    parameter  int WIDTH        = 13,
    parameter  int DEPTH        = 249,
    parameter  int RAM_LATENCY  = 2,
    parameter  int MIN_INTERVAL = 512,
    localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               UPDATE,
    output logic               BUSY,
    output logic               RAM_EN,
    output logic [AW-1:0]      RAM_ADDR,
    input  logic [3*WIDTH-1:0] RAM_DATA,
    output logic [WIDTH-1:0]   CYCLE [DEPTH],
    output logic [WIDTH-1:0]   DUTY  [DEPTH],
    output logic [WIDTH-1:0]   PHASE [DEPTH],
    output logic               START
);

    localparam int CW = $clog2(MIN_INTERVAL + 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_GAP} state_t;

    state_t               state, state_nx;
    logic                 pending;
    logic [CW-1:0]        gap_cnt;
    logic [RAM_LATENCY-1:0] vld_pipe;
    logic [AW-1:0]        idx_pipe [RAM_LATENCY];
    logic                 go, commit, cap, last_cap;

    logic [WIDTH-1:0] stg_c [DEPTH];
    logic [WIDTH-1:0] stg_d [DEPTH];
    logic [WIDTH-1:0] stg_p [DEPTH];

    logic [WIDTH-1:0] raw_c, raw_d, raw_p, san_d, san_p;

    // The address pipeline tracks which staging slot the word arriving now belongs to.
    assign cap      = vld_pipe[RAM_LATENCY-1];
    assign last_cap = cap && (idx_pipe[RAM_LATENCY-1] == AW'(DEPTH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (UPDATE || pending) state_nx = FETCH;
            FETCH:    if (last_cap) state_nx = WAIT_GAP;
            WAIT_GAP: if (gap_cnt >= CW'(MIN_INTERVAL)) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        go     = (state == IDLE) && (UPDATE || pending);
        commit = (state == WAIT_GAP) && (gap_cnt >= CW'(MIN_INTERVAL));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending  <= 1'b0;
            gap_cnt  <= CW'(MIN_INTERVAL);
            BUSY     <= 1'b0;
            RAM_EN   <= 1'b0;
            RAM_ADDR <= '0;
            START    <= 1'b0;
            vld_pipe <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) idx_pipe[i] <= '0;
        end else begin
            START   <= commit;
            BUSY    <= (state_nx != IDLE) || commit;
            pending <= (pending || (UPDATE && BUSY)) && !go;
            if (START)
                gap_cnt <= '0;
            else if (gap_cnt < CW'(MIN_INTERVAL))
                gap_cnt <= gap_cnt + CW'(1);
            if (go) begin
                RAM_EN   <= 1'b1;
                RAM_ADDR <= '0;
            end else if (RAM_EN) begin
                if (RAM_ADDR == AW'(DEPTH - 1)) begin
                    RAM_EN   <= 1'b0;
                    RAM_ADDR <= '0;
                end else begin
                    RAM_ADDR <= RAM_ADDR + AW'(1);
                end
            end
            vld_pipe[0] <= RAM_EN;
            idx_pipe[0] <= RAM_ADDR;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign raw_c = RAM_DATA[3*WIDTH-1:2*WIDTH];
    assign raw_d = RAM_DATA[2*WIDTH-1:WIDTH];
    assign raw_p = RAM_DATA[WIDTH-1:0];

    always_comb begin
        san_d = raw_d;
        san_p = raw_p;
        if (raw_c == '0) begin
            san_d = '0;
            san_p = '0;
        end else begin
            if (raw_d > (raw_c >> 1)) san_d = raw_c >> 1;
            if (raw_p >= raw_c)       san_p = raw_p - raw_c;
        end
    end

    // Staging is fully overwritten by every pass, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (cap) begin
            stg_c[idx_pipe[RAM_LATENCY-1]] <= raw_c;
            stg_d[idx_pipe[RAM_LATENCY-1]] <= san_d;
            stg_p[idx_pipe[RAM_LATENCY-1]] <= san_p;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                CYCLE[i] <= '0;
                DUTY[i]  <= '0;
                PHASE[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                CYCLE[i] <= stg_c[i];
                DUTY[i]  <= stg_d[i];
                PHASE[i] <= stg_p[i];
            end
        end
    end

endmodule
